// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target controller.
package i2c_pkg;

  localparam int I2C_ADDR_W        = 7;
  localparam int I2C_BYTE_W        = 8;
  localparam int I2C_BITS_PER_XFER = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_target_ctrl_if.sv
// Bus-side and application-side signals of the I2C target controller.
interface i2c_target_ctrl_if
  import i2c_pkg::*;
#(
  parameter int PTR_W = 8
);
  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_drive_low;
  logic                  busy;
  logic                  wr_valid;
  logic [PTR_W-1:0]      wr_ptr;
  logic [I2C_BYTE_W-1:0] wr_data;
  logic                  rd_strobe;
  logic [PTR_W-1:0]      rd_ptr;
  logic [I2C_BYTE_W-1:0] rd_data;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_drive_low, busy, wr_valid, wr_ptr, wr_data, rd_strobe, rd_ptr
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_drive_low, busy, wr_valid, wr_ptr, wr_data, rd_strobe, rd_ptr
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a stable-sample filter; emits one-cycle rise/fall
// pulses in the same cycle the filtered level changes.
module i2c_line_filter #(
  parameter int   FILTER_LEN = 2,
  parameter logic RESET_VAL  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CNT_W = $clog2(FILTER_LEN) + 1;

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             rise_q, fall_q;
  logic             accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A change is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    accept  = 1'b0;
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        accept  = 1'b1;
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {2{RESET_VAL}};
      level_q <= RESET_VAL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= accept & sync_q[1];
      fall_q  <= accept & ~sync_q[1];
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target: START/STOP detection, address match, pointer/write/read byte
// handling with an auto-incrementing register pointer.
module i2c_target_ctrl
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int                    FILTER_LEN  = 2,
  parameter int                    PTR_W       = 8
) (
  input logic               system_clock,
  input logic               reset_n,
  i2c_target_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(I2C_BITS_PER_XFER + 1);

  localparam logic [3:0] IDLE      = ST_IDLE;
  localparam logic [3:0] ADDR      = ST_ADDR;
  localparam logic [3:0] ADDR_ACK  = ST_ADDR_ACK;
  localparam logic [3:0] PTR       = ST_PTR;
  localparam logic [3:0] PTR_ACK   = ST_PTR_ACK;
  localparam logic [3:0] WDATA     = ST_WDATA;
  localparam logic [3:0] WDATA_ACK = ST_WDATA_ACK;
  localparam logic [3:0] RDATA     = ST_RDATA;
  localparam logic [3:0] RACK      = ST_RACK;
  localparam logic [3:0] IGNORE    = ST_IGNORE;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_evt, stop_evt;

  logic [3:0]            state_q, state_d;
  logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  sda_q, sda_d;
  logic                  busy_q, busy_d;
  logic                  rw_q, rw_d;
  logic                  nack_q, nack_d;
  logic                  load_rd, wr_valid_c, rd_strobe_c;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_scl_filt (
    .clk_i  (system_clock),
    .rst_ni (reset_n),
    .line_i (bus.scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_sda_filt (
    .clk_i  (system_clock),
    .rst_ni (reset_n),
    .line_i (bus.sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_evt = sda_fall & scl_lvl;
  assign stop_evt  = sda_rise & scl_lvl;

  // Bus conditions win over any bit event arriving in the same cycle.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_d       = sda_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    load_rd     = 1'b0;
    wr_valid_c  = 1'b0;
    rd_strobe_c = 1'b0;

    if (start_evt) begin
      busy_d   = 1'b1;
      bitcnt_d = '0;
      sda_d    = 1'b0;
      state_d  = ADDR;
    end else if (stop_evt) begin
      busy_d  = 1'b0;
      sda_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d  = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end else if (scl_fall && bitcnt_q == CNT_W'(I2C_BYTE_W)) begin
            bitcnt_d = '0;
            if (state_q == ADDR) begin
              if (shift_q[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                sda_d   = 1'b1;
                rw_d    = shift_q[0];
                state_d = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == PTR) begin
              ptr_d   = PTR_W'(shift_q);
              sda_d   = 1'b1;
              state_d = PTR_ACK;
            end else begin
              wr_valid_c = 1'b1;
              ptr_d      = ptr_q + PTR_W'(1);
              sda_d      = 1'b1;
              state_d    = WDATA_ACK;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_d    = 1'b0;
            bitcnt_d = '0;
            if (state_q == ADDR_ACK) begin
              if (rw_q) load_rd = 1'b1;
              else      state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (bitcnt_q == CNT_W'(I2C_BYTE_W)) begin
              sda_d   = 1'b0;
              state_d = RACK;
            end else begin
              shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
              sda_d   = ~shift_q[I2C_BYTE_W-2];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            nack_d = sda_lvl;
          end else if (scl_fall) begin
            if (!nack_q) load_rd = 1'b1;
            else         state_d = IGNORE;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase

      // rd_data is sampled in the strobe cycle; its MSB goes straight onto the wire.
      if (load_rd) begin
        rd_strobe_c = 1'b1;
        shift_d     = bus.rd_data;
        sda_d       = ~bus.rd_data[I2C_BYTE_W-1];
        ptr_d       = ptr_q + PTR_W'(1);
        bitcnt_d    = '0;
        state_d     = RDATA;
      end
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      sda_q    <= 1'b0;
      busy_q   <= 1'b0;
      rw_q     <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
      rw_q     <= rw_d;
      nack_q   <= nack_d;
    end
  end

  assign bus.sda_drive_low = sda_q & ~(start_evt | stop_evt);
  assign bus.busy          = busy_q;
  assign bus.wr_valid      = wr_valid_c;
  assign bus.wr_ptr        = ptr_q;
  assign bus.wr_data       = shift_q;
  assign bus.rd_strobe     = rd_strobe_c;
  assign bus.rd_ptr        = ptr_q;
endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Directed bench for i2c_target_ctrl: bit-banged I2C master, open-drain SDA
// modelled as wired-AND, application returns rd_data = ~rd_ptr.
module tb_i2c_target_ctrl;
  logic clk = 1'b0;
  logic resetN;
  logic sclM, sdaM;
  int   checkCount = 0;
  int   passCount  = 0;
  int   lowCount   = 0;
  logic [15:0] wrLog[$];
  logic [7:0]  rdLog[$];

  i2c_target_ctrl_if #(.PTR_W(8)) bus ();

  assign bus.scl_i   = sclM;
  assign bus.sda_i   = sdaM & ~bus.sda_drive_low;
  assign bus.rd_data = ~bus.rd_ptr;

  i2c_target_ctrl #(.TARGET_ADDR(7'h50), .FILTER_LEN(2), .PTR_W(8)) dut (
    .system_clock(clk),
    .reset_n     (resetN),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_valid)      wrLog.push_back({bus.wr_ptr, bus.wr_data});
    if (bus.rd_strobe)     rdLog.push_back(bus.rd_ptr);
    if (bus.sda_drive_low) lowCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; optional one-cycle SDA glitch in the middle of SCL high.
  task automatic applyStimulus(input logic b, input logic glitch, output logic sampled);
    cyc(5);
    sdaM = b;
    cyc(5);
    sclM = 1'b1;
    cyc(3);
    if (glitch) begin
      sdaM = ~b;
      cyc(1);
      sdaM = b;
      cyc(1);
    end else begin
      cyc(2);
    end
    sampled = bus.sda_i;
    cyc(5);
    sclM = 1'b0;
  endtask

  task automatic startCond();
    sdaM = 1'b1;
    cyc(10);
    sclM = 1'b1;
    cyc(10);
    sdaM = 1'b0;
    cyc(10);
    sclM = 1'b0;
  endtask

  task automatic stopCond();
    cyc(5);
    sdaM = 1'b0;
    cyc(10);
    sclM = 1'b1;
    cyc(10);
    sdaM = 1'b1;
    cyc(10);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack, input int glitchBit = -1);
    logic rb;
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], (i == glitchBit), rb);
    applyStimulus(1'b1, 1'b0, ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] d);
    logic rb;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, rb);
      d = {d[6:0], rb};
    end
    applyStimulus(masterAck ? 1'b0 : 1'b1, 1'b0, rb);
  endtask

  initial begin
    logic       ack;
    logic [7:0] data;
    int         wrBase, rdBase, lowBase;

    resetN = 1'b0;
    sclM   = 1'b1;
    sdaM   = 1'b1;
    cyc(5);
    checkOutput("reset sda_drive_low", bus.sda_drive_low, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset wr_valid", bus.wr_valid, 0);
    checkOutput("reset rd_strobe", bus.rd_strobe, 0);
    checkOutput("reset rd_ptr", bus.rd_ptr, 0);
    resetN = 1'b1;
    cyc(5);

    // Write: pointer 0x10 then two data bytes
    wrBase = wrLog.size();
    startCond();
    checkOutput("t1 busy after start", bus.busy, 1);
    writeByte(8'hA0, ack); checkOutput("t1 addr ack", ack, 0);
    writeByte(8'h10, ack); checkOutput("t1 ptr ack", ack, 0);
    writeByte(8'h5A, ack); checkOutput("t1 data0 ack", ack, 0);
    writeByte(8'hC3, ack); checkOutput("t1 data1 ack", ack, 0);
    stopCond();
    checkOutput("t1 busy after stop", bus.busy, 0);
    checkOutput("t1 write count", wrLog.size() - wrBase, 2);
    checkOutput("t1 write0", wrLog[wrBase], 16'h105A);
    checkOutput("t1 write1", wrLog[wrBase + 1], 16'h11C3);

    // Read with repeated start
    wrBase = wrLog.size();
    rdBase = rdLog.size();
    startCond();
    writeByte(8'hA0, ack); checkOutput("t2 addr ack", ack, 0);
    writeByte(8'h20, ack); checkOutput("t2 ptr ack", ack, 0);
    startCond();
    writeByte(8'hA1, ack); checkOutput("t2 read addr ack", ack, 0);
    readByte(1'b1, data);  checkOutput("t2 read byte0", data, 8'hDF);
    readByte(1'b0, data);  checkOutput("t2 read byte1", data, 8'hDE);
    stopCond();
    checkOutput("t2 rd_strobe count", rdLog.size() - rdBase, 2);
    checkOutput("t2 rd_ptr0", rdLog[rdBase], 8'h20);
    checkOutput("t2 rd_ptr1", rdLog[rdBase + 1], 8'h21);
    checkOutput("t2 final ptr", bus.rd_ptr, 8'h22);
    checkOutput("t2 no writes", wrLog.size() - wrBase, 0);
    checkOutput("t2 busy after stop", bus.busy, 0);

    // Address mismatch, then a matching transaction
    wrBase  = wrLog.size();
    rdBase  = rdLog.size();
    lowBase = lowCount;
    startCond();
    writeByte(8'hA2, ack); checkOutput("t3 mismatch addr nack", ack, 1);
    writeByte(8'h55, ack); checkOutput("t3 ignored byte nack", ack, 1);
    stopCond();
    checkOutput("t3 sda never low", lowCount - lowBase, 0);
    checkOutput("t3 no writes", wrLog.size() - wrBase, 0);
    checkOutput("t3 no reads", rdLog.size() - rdBase, 0);
    startCond();
    writeByte(8'hA0, ack); checkOutput("t3 next addr ack", ack, 0);
    writeByte(8'h40, ack); checkOutput("t3 next ptr ack", ack, 0);
    writeByte(8'h99, ack); checkOutput("t3 next data ack", ack, 0);
    stopCond();
    checkOutput("t3 next write count", wrLog.size() - wrBase, 1);
    checkOutput("t3 next write", wrLog[wrBase], 16'h4099);

    // Glitches: idle SDA dip, and a would-be STOP inside a data bit
    cyc(5);
    sdaM = 1'b0;
    cyc(1);
    sdaM = 1'b1;
    cyc(15);
    checkOutput("t5 idle glitch busy", bus.busy, 0);
    wrBase = wrLog.size();
    startCond();
    writeByte(8'hA0, ack); checkOutput("t5 addr ack", ack, 0);
    writeByte(8'h30, ack); checkOutput("t5 ptr ack", ack, 0);
    writeByte(8'h00, ack, 7);
    checkOutput("t5 glitched byte ack", ack, 0);
    checkOutput("t5 busy held", bus.busy, 1);
    stopCond();
    checkOutput("t5 write count", wrLog.size() - wrBase, 1);
    checkOutput("t5 write", wrLog[wrBase], 16'h3000);

    // Pointer wrap
    wrBase = wrLog.size();
    startCond();
    writeByte(8'hA0, ack);
    writeByte(8'hFF, ack);
    writeByte(8'h01, ack);
    writeByte(8'h02, ack);
    stopCond();
    checkOutput("t4 write count", wrLog.size() - wrBase, 2);
    checkOutput("t4 write at 0xFF", wrLog[wrBase], 16'hFF01);
    checkOutput("t4 write wrapped", wrLog[wrBase + 1], 16'h0002);
    checkOutput("t4 final ptr", bus.rd_ptr, 8'h01);

    // Reset while the target drives a 0 read bit
    rdBase = rdLog.size();
    startCond();
    writeByte(8'hA0, ack);
    writeByte(8'h80, ack);
    startCond();
    writeByte(8'hA1, ack); checkOutput("t6 read addr ack", ack, 0);
    cyc(8);
    sclM = 1'b1;
    cyc(5);
    checkOutput("t6 driving bit0 low", bus.sda_drive_low, 1);
    checkOutput("t6 rd_strobe ptr", rdLog[rdBase], 8'h80);
    checkOutput("t6 ptr before reset", bus.rd_ptr, 8'h81);
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    checkOutput("t6 async release", bus.sda_drive_low, 0);
    checkOutput("t6 busy cleared", bus.busy, 0);
    checkOutput("t6 ptr cleared", bus.rd_ptr, 0);
    sdaM = 1'b1;
    cyc(5);
    resetN = 1'b1;
    cyc(10);
    wrBase = wrLog.size();
    startCond();
    writeByte(8'hA0, ack); checkOutput("t6 post-reset addr ack", ack, 0);
    writeByte(8'h05, ack);
    writeByte(8'h77, ack); checkOutput("t6 post-reset data ack", ack, 0);
    stopCond();
    checkOutput("t6 post-reset write", wrLog[wrBase], 16'h0577);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
